// File: rtl/iccm_controller_if.sv
// Bus between the fetch/loader requester, the ICCM controller and the SRAM macro.
// The controller uses the slave view; the requester/SRAM side uses the master view.
interface iccm_controller_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  cntlr_rd;
  logic [ADDR_WIDTH-1:0] cntlr_raddr;
  logic [DATA_WIDTH-1:0] cntlr_rd_data;
  logic                  cntlr_rd_valid;
  logic                  cntlr_wr;
  logic [ADDR_WIDTH-1:0] cntlr_waddr;
  logic [DATA_WIDTH-1:0] cntlr_wr_data;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport slave (
    input  cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, mem_rd_data,
    output cntlr_rd_data, cntlr_rd_valid, mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
  );

  modport master (
    output cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, mem_rd_data,
    input  cntlr_rd_data, cntlr_rd_valid, mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/iccm_controller.sv
// Pipelined ICCM access controller: one-stage write path, two-stage read path.
// Optional macro ICCM_RAW_BYPASS_EN forwards same-edge write data to a colliding read.
module iccm_controller #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  iccm_controller_if.slave bus
);

  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

`ifdef ICCM_RAW_BYPASS_EN
  logic raw_hit_q, raw_hit_d;
`endif

  always_comb begin
    mem_rd_d      = bus.cntlr_rd;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_wr_d      = bus.cntlr_wr;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_valid_d    = mem_rd_q;
    rd_data_d     = rd_data_q;
    if (bus.cntlr_rd) mem_rd_addr_d = bus.cntlr_raddr;
    if (bus.cntlr_wr) begin
      mem_wr_addr_d = bus.cntlr_waddr;
      mem_wr_data_d = bus.cntlr_wr_data;
    end
`ifdef ICCM_RAW_BYPASS_EN
    raw_hit_d = bus.cntlr_rd && bus.cntlr_wr && (bus.cntlr_raddr == bus.cntlr_waddr);
    // On a hit the registered write data is the forwarded value; the SRAM has not committed it yet.
    if (mem_rd_q) rd_data_d = raw_hit_q ? mem_wr_data_q : bus.mem_rd_data;
`else
    if (mem_rd_q) rd_data_d = bus.mem_rd_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rd_q      <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_q      <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
`ifdef ICCM_RAW_BYPASS_EN
      raw_hit_q     <= 1'b0;
`endif
    end else begin
      mem_rd_q      <= mem_rd_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_wr_q      <= mem_wr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
`ifdef ICCM_RAW_BYPASS_EN
      raw_hit_q     <= raw_hit_d;
`endif
    end
  end

  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_rd_addr    = mem_rd_addr_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.mem_wr_addr    = mem_wr_addr_q;
  assign bus.mem_wr_data    = mem_wr_data_q;
  assign bus.cntlr_rd_data  = rd_data_q;
  assign bus.cntlr_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_iccm_controller.sv
// Self-checking bench for iccm_controller: directed scenarios then randomized traffic,
// compared every cycle against a word-array reference of the ICCM contents.
module tb_iccm_controller;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int WORDS = 1 << AW;

  logic clk;
  logic rst_n;
  iccm_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  iccm_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: combinational read gated by rd_en, write committed on the rising edge.
  logic [DW-1:0] sram [WORDS];
  assign bus.mem_rd_data = bus.mem_rd ? sram[bus.mem_rd_addr] : '0;
  always @(posedge clk) if (bus.mem_wr) sram[bus.mem_wr_addr] <= bus.mem_wr_data;

  logic [DW-1:0] refMem [WORDS];
  int numChecks = 0;
  int numErrors = 0;

  logic          expValid, expMemRd, expMemWr, pendValid, wrAddrKnown;
  logic [DW-1:0] expData, pendData, expMemWrData;
  logic [AW-1:0] expMemRdAddr, expMemWrAddr;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  // Drive one edge worth of requests, advance the reference, then compare all outputs.
  task automatic applyStimulus(input logic rstn, input logic rd, input logic [AW-1:0] raddr,
                               input logic wr, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    logic [DW-1:0] readResult;
    @(negedge clk);
    rst_n             = rstn;
    bus.cntlr_rd      = rd;
    bus.cntlr_raddr   = raddr;
    bus.cntlr_wr      = wr;
    bus.cntlr_waddr   = waddr;
    bus.cntlr_wr_data = wdata;
    @(posedge clk);
    if (!rstn) begin
      expValid = 1'b0; expData = '0; expMemRd = 1'b0; expMemRdAddr = '0;
      expMemWr = 1'b0; expMemWrAddr = '0; expMemWrData = '0;
      wrAddrKnown = 1'b1; pendValid = 1'b0;
    end else begin
      expValid = pendValid;
      if (pendValid) expData = pendData;
      expMemRd = rd;
      if (rd) expMemRdAddr = raddr;
      expMemWr = wr;
      wrAddrKnown = wr;
      if (wr) begin expMemWrAddr = waddr; expMemWrData = wdata; end
      readResult = refMem[raddr];
`ifdef ICCM_RAW_BYPASS_EN
      if (wr && (waddr == raddr)) readResult = wdata;
`endif
      pendValid = rd;
      pendData  = readResult;
      if (wr) refMem[waddr] = wdata;
    end
    #1;
    checkOutput("rd_valid", {31'b0, bus.cntlr_rd_valid}, {31'b0, expValid});
    checkOutput("rd_data", bus.cntlr_rd_data, expData);
    checkOutput("mem_rd", {31'b0, bus.mem_rd}, {31'b0, expMemRd});
    checkOutput("mem_rd_addr", {21'b0, bus.mem_rd_addr}, {21'b0, expMemRdAddr});
    checkOutput("mem_wr", {31'b0, bus.mem_wr}, {31'b0, expMemWr});
    if (wrAddrKnown) begin
      checkOutput("mem_wr_addr", {21'b0, bus.mem_wr_addr}, {21'b0, expMemWrAddr});
      checkOutput("mem_wr_data", bus.mem_wr_data, expMemWrData);
    end
  endtask

  function automatic logic [AW-1:0] pickAddr();
    int sel;
    sel = int'($urandom_range(0, 5));
    case (sel)
      4:       return AW'(WORDS - 2);
      5:       return AW'(WORDS - 1);
      default: return AW'(sel);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sram[i]   = '0;
      refMem[i] = '0;
    end
    rst_n = 1'b0;
    bus.cntlr_rd = 1'b0; bus.cntlr_raddr = '0;
    bus.cntlr_wr = 1'b0; bus.cntlr_waddr = '0; bus.cntlr_wr_data = '0;
    expValid = 1'b0; expData = '0; expMemRd = 1'b0; expMemRdAddr = '0;
    expMemWr = 1'b0; expMemWrAddr = '0; expMemWrData = '0;
    pendValid = 1'b0; pendData = '0; wrAddrKnown = 1'b1;

    $display("[TB] reset with requests active");
    applyStimulus(1'b0, 1'b1, 11'd3, 1'b1, 11'd3, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 11'd4, 1'b1, 11'd4, 32'h87654321);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);

    $display("[TB] write then read");
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b1, 11'd10, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b1, 11'd10, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 11'd10, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);

    $display("[TB] pipelined reads");
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b1, 11'd1, 32'h11);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b1, 11'd2, 32'h22);
    applyStimulus(1'b1, 1'b1, 11'd1, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 11'd2, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);

    $display("[TB] same-edge collision");
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b1, 11'd5, 32'hAAAA0000);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 11'd5, 1'b1, 11'd5, 32'h5555FFFF);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 11'd5, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);

    $display("[TB] boundary addresses");
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b1, 11'd2047, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b1, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 11'd2047, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);

    $display("[TB] reset mid-read");
    applyStimulus(1'b1, 1'b1, 11'd10, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 32'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 800; n++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    1'($urandom_range(0, 1)), pickAddr(),
                    1'($urandom_range(0, 1)), pickAddr(), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end
endmodule

// File: doc/iccm_controller.md
Name: iccm_controller

Overview:
- Pipelined access controller between an instruction-side requester and a single-port-read / single-port-write ICCM SRAM. The default SRAM is 2048 x 32 bits (8 KB).
- Registers read and write requests onto the SRAM interface, then captures SRAM read data and returns it with a one-cycle valid strobe.
- Sits between the fetch/loader logic and the SRAM macro. The SRAM read is combinational in address (gated by rd_en); the SRAM write is synchronous.

Parameters:
- ADDR_WIDTH, 11, word address width (2^ADDR_WIDTH words).
- DATA_WIDTH, 32, word width in bits.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cntlr_rd  in  1  read request, sampled each rising edge.
- cntlr_raddr  in  ADDR_WIDTH  read word address.
- cntlr_rd_data  out  DATA_WIDTH  read data, registered.
- cntlr_rd_valid  out  1  high for exactly one cycle when cntlr_rd_data holds a new read result.
- cntlr_wr  in  1  write request, sampled each rising edge.
- cntlr_waddr  in  ADDR_WIDTH  write word address.
- cntlr_wr_data  in  DATA_WIDTH  write data.
- mem_rd  out  1  SRAM read enable.
- mem_rd_addr  out  ADDR_WIDTH  SRAM read address.
- mem_rd_data  in  DATA_WIDTH  SRAM read data, combinational from mem_rd_addr.
- mem_wr  out  1  SRAM write enable.
- mem_wr_addr  out  ADDR_WIDTH  SRAM write address.
- mem_wr_data  out  DATA_WIDTH  SRAM write data.

Behaviour:
- Reset:
  - On a rising edge with rst_n=0, all output registers clear to 0: mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data, cntlr_rd_data, cntlr_rd_valid.
  - Requests sampled on a reset edge are discarded.
  - A write already driven on mem_wr at the reset edge still completes in the SRAM, because the SRAM samples before the clear takes effect.
  - Read results in flight are dropped; no valid is produced for them.
- Write path, one stage:
  - cntlr_wr=1 sampled at edge T sets mem_wr=1, mem_wr_addr=cntlr_waddr, mem_wr_data=cntlr_wr_data for the cycle T..T+1.
  - The SRAM commits the write at edge T+1.
  - mem_wr deasserts at T+1 if no new write is sampled.
- Write throughput and ordering:
  - One write accepted every cycle, with no backpressure.
  - Back-to-back writes to the same address: the last one wins.
- Read path, two stages:
  - cntlr_rd=1 sampled at edge T sets mem_rd=1, mem_rd_addr=cntlr_raddr for T..T+1.
  - At edge T+1 the controller captures mem_rd_data into cntlr_rd_data and sets cntlr_rd_valid=1 for cycle T+1..T+2.
  - Total latency from request edge to valid: 1 cycle, with data stable while valid is high.
  - Reads are fully pipelined: one per cycle, valids back-to-back.
- Read data hold:
  - When cntlr_rd_valid=0, cntlr_rd_data holds the last captured value.
  - mem_rd_addr holds its last value when mem_rd=0.
- Read-after-write ordering:
  - A read sampled at any edge after the edge that sampled a write to the same address returns the new data.
- Simultaneous read and write sampled at the same edge, both accepted independently:
  - Different addresses: no interaction.
  - Same address, default build: the read returns the pre-write memory contents (read-before-write).
- Addresses wrap naturally within ADDR_WIDTH; there is no out-of-range check.
- No FSM beyond the pipeline registers; the controller is always ready.

Optional Feature:
- Macro ICCM_RAW_BYPASS_EN.
- Defined:
  - A read and write sampled at the same edge with cntlr_raddr==cntlr_waddr forward the write data.
  - At T+1, cntlr_rd_data = the write data instead of mem_rd_data; valid timing is unchanged.
  - Implemented with a registered compare flag and a registered copy of the write data.
- Undefined: read-before-write semantics as described above, and no compare logic is instantiated.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with requests active -> all outputs 0; no mem_wr, no mem_rd, no valid after reset.
- Write then read: write 32'hDEADBEEF to addr 10 (wr held 2 cycles), deassert, later read addr 10 -> mem_wr=1 with addr 10 and data DEADBEEF the cycle after each sample; cntlr_rd_valid pulses once, 1 cycle after the read sample, with cntlr_rd_data=32'hDEADBEEF; data held after valid drops.
- Pipelined reads: write 0x11 to addr 1 and 0x22 to addr 2, then read 1 and 2 on consecutive edges -> valid high for 2 consecutive cycles with data 0x11 then 0x22.
- Same-edge collision: addr 5 holds 0xAAAA0000; issue write 0x5555FFFF and read to addr 5 at the same edge -> default build returns 0xAAAA0000; with ICCM_RAW_BYPASS_EN returns 0x5555FFFF; a later read returns 0x5555FFFF in both builds.
- Wrap/boundary: write 0xCAFEF00D to addr 2047 and 0x0 to addr 0, then read both -> correct per-address data, no aliasing.
- Reset mid-read: sample a read, assert rst_n=0 at the next edge -> no valid pulse; cntlr_rd_data=0.
